// File: rtl/vedic_mul_seq.sv
// ----------------------------------------------------------------------------
// vedic_mul_seq
// Multi-cycle signed/unsigned WIDTH x WIDTH multiplier built from 2x2 Vedic
// cells. Each busy cycle multiplies the latched multiplicand magnitude by one
// 2-bit digit of the multiplier magnitude and accumulates that partial product,
// shifted into place, into a 2*WIDTH accumulator. The sign is applied once at
// the end when the product is loaded into the output register.
// ----------------------------------------------------------------------------

// 2x2 Vedic (Urdhva-Tiryagbhyam) cell: vertical and crosswise products.
module vedic2x2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] z
);
    logic vert_lo;
    logic cross_a;
    logic cross_b;
    logic vert_hi;
    logic cross_carry;

    assign vert_lo     = x[0] & y[0];
    assign cross_a     = x[1] & y[0];
    assign cross_b     = x[0] & y[1];
    assign vert_hi     = x[1] & y[1];
    assign cross_carry = cross_a & cross_b;

    assign z[0] = vert_lo;
    assign z[1] = cross_a ^ cross_b;
    assign z[2] = vert_hi ^ cross_carry;
    assign z[3] = vert_hi & cross_carry;
endmodule

module vedic_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);
    // Number of 2-bit digits in an operand, and the counter that walks them.
    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW     = 2 * WIDTH;
    localparam int PPW    = WIDTH + 2;   // |a| * 3 always fits in WIDTH+2 bits

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_PW   = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg;
    logic [PW-1:0]        acc;
    logic [CNT_W-1:0]     cnt;

    // Operand magnitudes at the input. -2^(W-1) negates to itself, which read
    // as an unsigned W-bit value is exactly the required magnitude 2^(W-1).
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic                 neg_in;

    // Magnitude and sign extraction for the operands presented at accept.
    always_comb begin
        a_abs  = a;
        b_abs  = b;
        neg_in = 1'b0;
        if (op_signed) begin
            if (a[WIDTH-1]) begin
                a_abs = (~a) + ONE_W;
            end
            if (b[WIDTH-1]) begin
                b_abs = (~b) + ONE_W;
            end
            neg_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    // Current multiplier digit and its bit offset within the product.
    logic [CNT_W:0]       shamt;
    logic [1:0]           digit;

    assign shamt = {cnt, 1'b0};
    assign digit = 2'(b_mag >> shamt);

    // One Vedic cell per 2-bit slice of the multiplicand; each cell output is
    // placed at its slice offset before summation.
    logic [3:0]           cell_prod [DIGITS];
    logic [PPW-1:0]       cell_term [DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_cell
            vedic2x2 u_cell (
                .x (a_mag[2*gi+1:2*gi]),
                .y (digit),
                .z (cell_prod[gi])
            );
            assign cell_term[gi] = PPW'(cell_prod[gi]) << (2 * gi);
        end
    endgenerate

    // Partial product |a| * digit as the sum of the placed cell outputs.
    logic [PPW-1:0]       pp;

    always_comb begin
        pp = '0;
        for (int k = 0; k < DIGITS; k++) begin
            pp = pp + cell_term[k];
        end
    end

    // Partial product shifted to the digit position and added to the
    // accumulator; the unsigned product never exceeds 2*WIDTH bits.
    logic [PW-1:0]        addend;
    logic [PW-1:0]        acc_next;
    logic [PW-1:0]        acc_neg;

    assign addend   = PW'(pp) << shamt;
    assign acc_next = acc + addend;
    assign acc_neg  = (~acc_next) + ONE_PW;

    // Control FSM with registered handshake outputs and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // marks the accept edge.
                    if (in_valid) begin
                        a_mag    <= a_abs;
                        b_mag    <= b_abs;
                        neg      <= neg_in;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + ONE_CNT;
                    if (cnt == LAST_CNT) begin
                        // Final digit: sign-correct the completed sum into p.
                        p         <= neg ? acc_neg : acc_next;
                        cnt       <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Hold p until the consumer takes it; no accept this edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vedic_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_vedic_mul_seq
// Directed checks of vedic_mul_seq (WIDTH=16): reset state, latency, signed
// and unsigned products including the -2^(W-1) corner, backpressure, ignored
// mid-operation requests and asynchronous reset during BUSY.
// ----------------------------------------------------------------------------
module tb_vedic_mul_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_signed;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vedic_mul_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_signed (op_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs one operation starting at posedge+1. hold = cycles of out_ready=0
    // after out_valid; glitch = pulse in_valid with other operands mid-BUSY.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sg, input logic [31:0] exp, input int hold, input bit glitch);
        int          n;
        logic [31:0] held;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        op_signed = sg;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs after accept: the latched copies must be used.
        in_valid  = 1'b0;
        a         = ~av;
        b         = bv ^ 16'h5a5a;
        op_signed = ~sg;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            if (glitch && n == 2) begin
                in_valid = 1'b1;
                a        = 16'h1234;
                b        = 16'h5678;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'd8);
        check({tag, ".p"}, p, exp);
        check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
        held = p;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_p"}, p, held);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
        $display("op %s a=%04h b=%04h s=%0d p=%08h exp=%08h", tag, av, bv, sg, p, exp);
    endtask

    initial begin
        logic [15:0]        ra;
        logic [15:0]        rb;
        logic               rs;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        rexp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_signed = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #22;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.p", p, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("u_ffff_ffff", 16'hffff, 16'hffff, 1'b0, 32'hfffe0001, 0, 1'b0);
        run_op("s_m1_m1",     16'hffff, 16'hffff, 1'b1, 32'h00000001, 0, 1'b0);
        run_op("s_min_min",   16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, 1'b0);
        run_op("s_min_one",   16'h8000, 16'h0001, 1'b1, 32'hffff8000, 0, 1'b0);
        run_op("s_max_min",   16'h7fff, 16'h8000, 1'b1, 32'hc0008000, 0, 1'b0);
        run_op("u_min_min",   16'h8000, 16'h8000, 1'b0, 32'h40000000, 0, 1'b0);
        run_op("s_zero_neg",  16'h0000, 16'hffff, 1'b1, 32'h00000000, 0, 1'b0);
        run_op("s_m2_3",      16'hfffe, 16'h0003, 1'b1, 32'hfffffffa, 0, 1'b0);
        run_op("u_shift",     16'h1234, 16'h0010, 1'b0, 32'h00012340, 0, 1'b0);
        run_op("u_backpress", 16'h00ff, 16'h0101, 1'b0, 32'h0000ffff, 5, 1'b0);
        run_op("u_glitch",    16'h0003, 16'h0005, 1'b0, 32'h0000000f, 0, 1'b1);

        // Asynchronous reset with the digit counter at 3.
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h5678;
        op_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.p", p, 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 16'h0003, 16'h0005, 1'b0, 32'd15, 0, 1'b0);

        // Random operands against the behavioural product.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (rs) begin
                sa   = {{16{ra[15]}}, ra};
                sb   = {{16{rb[15]}}, rb};
                rexp = 32'(sa * sb);
            end else begin
                rexp = {16'd0, ra} * {16'd0, rb};
            end
            run_op("rand", ra, rb, rs, rexp, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
